seg_scan_ctrl: RTL and testbench

Time-multiplexing scheduler that shares one 7-segment segment bus among DIGITS common-anode/cathode digits.
It takes a packed hex value (e.g. the debounced key counter widened to several nibbles), latches it once per frame, and sequences digit enables with a blanking gap between digits to prevent ghosting.
It sits between the counter datapath and the board's segment/anode pins, and replaces the single-digit LED encoder when more than one digit is driven.

---
 rtl/seg_scan_ctrl_if.sv | 21 ++
 rtl/seg_scan_ctrl.sv | 144 ++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/seg_scan_ctrl_if.sv
// Bus between the hex value source and the digit scanner.
// en/value flow master->slave; seg/an/frame_done flow back.
interface seg_scan_ctrl_if #(
    parameter int DIGITS = 4
);
    logic                  en;
    logic [4*DIGITS-1:0]   value;
    logic [6:0]            seg;
    logic [DIGITS-1:0]     an;
    logic                  frame_done;

    modport master (
        output en, value,
        input  seg, an, frame_done
    );

    modport slave (
        input  en, value,
        output seg, an, frame_done
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scanner: one shared seg bus, DIGITS anodes.
// Ports: clk, rst (sync, active-high), bus.{en,value,seg,an,frame_done}.
module seg_scan_ctrl #(
    parameter int DIGITS      = 4,
    parameter int DWELL       = 50000,
    parameter int BLANK       = 500,
    parameter bit ACTIVE_LOW  = 1'b1,
    parameter bit LZ_SUPPRESS = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    seg_scan_ctrl_if.slave bus
);
    localparam int CMAX = (DWELL > BLANK) ?
                          ((DWELL > 2) ? DWELL : 2) :
                          ((BLANK > 2) ? BLANK : 2);
    localparam int CW = $clog2(CMAX);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CW-1:0] DLAST = CW'(DWELL - 1);
    localparam logic [CW-1:0] BLAST = CW'((BLANK > 0) ? BLANK - 1 : 0);
    localparam logic [IW-1:0] ILAST = IW'(DIGITS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BLANK,
        S_DRIVE
    } state_t;

    // With no blank phase every slot starts straight in DRIVE.
    localparam state_t S_FIRST = (BLANK == 0) ? S_DRIVE : S_BLANK;

    state_t              st, ns;
    logic [IW-1:0]       idx, ni;
    logic [CW-1:0]       cnt, nc;
    logic [4*DIGITS-1:0] shadow, nsh;
    logic                nfd;
    logic [6:0]          seg_n;
    logic [DIGITS-1:0]   an_n;
    logic                sup;

    function automatic logic [6:0] dec(input logic [3:0] n);
        logic [6:0] p;
        unique case (n)
            4'h0: p = 7'h3F;
            4'h1: p = 7'h06;
            4'h2: p = 7'h5B;
            4'h3: p = 7'h4F;
            4'h4: p = 7'h66;
            4'h5: p = 7'h6D;
            4'h6: p = 7'h7D;
            4'h7: p = 7'h07;
            4'h8: p = 7'h7F;
            4'h9: p = 7'h6F;
            4'hA: p = 7'h77;
            4'hB: p = 7'h7C;
            4'hC: p = 7'h39;
            4'hD: p = 7'h5E;
            4'hE: p = 7'h79;
            default: p = 7'h71;
        endcase
        return p;
    endfunction

    always_comb begin
        ns  = st;
        ni  = idx;
        nc  = cnt;
        nsh = shadow;
        nfd = 1'b0;
        if (!bus.en) begin
            ns = S_IDLE;
            ni = '0;
            nc = '0;
        end else begin
            unique case (st)
                S_IDLE: begin
                    nsh = bus.value;
                    ni  = '0;
                    nc  = '0;
                    ns  = S_FIRST;
                end
                S_BLANK: begin
                    if (cnt == BLAST) begin
                        ns = S_DRIVE;
                        nc = '0;
                    end else begin
                        nc = cnt + 1'b1;
                    end
                end
                S_DRIVE: begin
                    if (cnt == DLAST) begin
                        nc = '0;
                        ns = S_FIRST;
                        if (idx == ILAST) begin
                            // Frame boundary: reload the snapshot here only.
                            ni  = '0;
                            nsh = bus.value;
                            nfd = 1'b1;
                        end else begin
                            ni = idx + 1'b1;
                        end
                    end else begin
                        nc = cnt + 1'b1;
                    end
                end
                default: ns = S_IDLE;
            endcase
        end
    end

    // Outputs are derived from the next state so that the registered
    // pins line up with the state register in the same cycle.
    always_comb begin
        seg_n = '0;
        an_n  = '0;
        sup   = LZ_SUPPRESS && (ni != '0) &&
                ((nsh >> {ni, 2'b00}) == '0);
        if (ns == S_DRIVE) begin
            an_n[ni] = 1'b1;
            if (!sup) seg_n = dec(nsh[{ni, 2'b00} +: 4]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st             <= S_IDLE;
            idx            <= '0;
            cnt            <= '0;
            shadow         <= '0;
            bus.seg        <= {7{ACTIVE_LOW}};
            bus.an         <= {DIGITS{ACTIVE_LOW}};
            bus.frame_done <= 1'b0;
        end else begin
            st             <= ns;
            idx            <= ni;
            cnt            <= nc;
            shadow         <= nsh;
            bus.seg        <= seg_n ^ {7{ACTIVE_LOW}};
            bus.an         <= an_n ^ {DIGITS{ACTIVE_LOW}};
            bus.frame_done <= nfd;
        end
    end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: three configurations against a timeline model.
// Ports exercised: clk, rst, en, value, seg, an, frame_done.
module tb_seg_scan_ctrl;
    localparam int N = 4;
    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [15:0] value;
    bit          chk_on = 1'b0;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    seg_scan_ctrl_if #(.DIGITS(N)) ifa ();
    seg_scan_ctrl_if #(.DIGITS(N)) ifb ();
    seg_scan_ctrl_if #(.DIGITS(N)) ifc ();

    assign ifa.en = en;
    assign ifb.en = en;
    assign ifc.en = en;
    assign ifa.value = value;
    assign ifb.value = value;
    assign ifc.value = value;

    seg_scan_ctrl #(.DIGITS(N), .DWELL(D), .BLANK(2),
                    .ACTIVE_LOW(1'b1), .LZ_SUPPRESS(1'b1))
        dut_a (.clk(clk), .rst(rst), .bus(ifa));
    seg_scan_ctrl #(.DIGITS(N), .DWELL(D), .BLANK(2),
                    .ACTIVE_LOW(1'b1), .LZ_SUPPRESS(1'b0))
        dut_b (.clk(clk), .rst(rst), .bus(ifb));
    seg_scan_ctrl #(.DIGITS(N), .DWELL(D), .BLANK(0),
                    .ACTIVE_LOW(1'b0), .LZ_SUPPRESS(1'b1))
        dut_c (.clk(clk), .rst(rst), .bus(ifc));

    // Timeline model: t is the cycle position inside the current frame.
    int          mb[3]  = '{2, 2, 0};
    bit          mal[3] = '{1'b1, 1'b1, 1'b0};
    bit          mlz[3] = '{1'b1, 1'b0, 1'b1};
    bit          run[3];
    int          t[3];
    logic [15:0] sh[3];
    bit          fd[3];
    logic [6:0]  dec[16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D,
                             7'h7D, 7'h07, 7'h7F, 7'h6F, 7'h77, 7'h7C,
                             7'h39, 7'h5E, 7'h79, 7'h71};

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            fd[k] = 1'b0;
            if (rst) begin
                run[k] = 1'b0;
                t[k]   = 0;
                sh[k]  = '0;
            end else if (!en) begin
                run[k] = 1'b0;
            end else if (!run[k]) begin
                run[k] = 1'b1;
                t[k]   = 0;
                sh[k]  = value;
            end else begin
                t[k] = t[k] + 1;
                if (t[k] == N * (mb[k] + D)) begin
                    t[k]  = 0;
                    sh[k] = value;
                    fd[k] = 1'b1;
                end
            end
        end
    end

    function automatic void model_out(input int k,
                                      output logic [6:0] s,
                                      output logic [3:0] a);
        int p, slot, off;
        logic [3:0] nib;
        bit sup;
        s = '0;
        a = '0;
        p = mb[k] + D;
        if (run[k]) begin
            slot = t[k] / p;
            off  = t[k] % p;
            if (off >= mb[k]) begin
                a   = 4'(1 << slot);
                nib = 4'(sh[k] >> (4 * slot));
                sup = mlz[k] && slot > 0 && ((sh[k] >> (4 * slot)) == 0);
                if (!sup) s = dec[nib];
            end
        end
        if (mal[k]) begin
            s = ~s;
            a = ~a;
        end
    endfunction

    logic [6:0] gseg[3];
    logic [3:0] gan[3];
    logic       gfd[3];
    assign gseg[0] = ifa.seg;
    assign gseg[1] = ifb.seg;
    assign gseg[2] = ifc.seg;
    assign gan[0]  = ifa.an;
    assign gan[1]  = ifb.an;
    assign gan[2]  = ifc.an;
    assign gfd[0]  = ifa.frame_done;
    assign gfd[1]  = ifb.frame_done;
    assign gfd[2]  = ifc.frame_done;

    always @(negedge clk) begin
        logic [6:0] es;
        logic [3:0] ea;
        if (chk_on) begin
            for (int k = 0; k < 3; k++) begin
                model_out(k, es, ea);
                checks++;
                if (gseg[k] !== es || gan[k] !== ea || gfd[k] !== fd[k]) begin
                    errors++;
                    $display("FAIL model dut%0d @%0t got seg=%h an=%h fd=%b want seg=%h an=%h fd=%b",
                             k, $time, gseg[k], gan[k], gfd[k], es, ea, fd[k]);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    typedef struct {
        int          n;
        logic        en;
        logic [15:0] val;
        logic [6:0]  seg;
        logic [3:0]  an;
        logic        fd;
    } vec_t;

    vec_t vt[12];

    initial begin
        vt[0]  = '{1, 1'b0, 16'h1234, 7'h7F, 4'hF, 1'b0};
        vt[1]  = '{1, 1'b1, 16'h1234, 7'h7F, 4'hF, 1'b0};
        vt[2]  = '{2, 1'b1, 16'h1234, 7'h19, 4'hE, 1'b0};
        vt[3]  = '{3, 1'b1, 16'h1234, 7'h19, 4'hE, 1'b0};
        vt[4]  = '{1, 1'b1, 16'h1234, 7'h7F, 4'hF, 1'b0};
        vt[5]  = '{2, 1'b1, 16'h1234, 7'h30, 4'hD, 1'b0};
        vt[6]  = '{6, 1'b1, 16'h1234, 7'h24, 4'hB, 1'b0};
        vt[7]  = '{6, 1'b1, 16'h1234, 7'h79, 4'h7, 1'b0};
        vt[8]  = '{3, 1'b1, 16'h1234, 7'h79, 4'h7, 1'b0};
        vt[9]  = '{1, 1'b1, 16'h1234, 7'h7F, 4'hF, 1'b1};
        vt[10] = '{1, 1'b1, 16'h1234, 7'h7F, 4'hF, 1'b0};
        vt[11] = '{23, 1'b1, 16'h1234, 7'h7F, 4'hF, 1'b1};

        rst   = 1'b1;
        en    = 1'b0;
        value = '0;
        @(negedge clk);
        chk_on = 1'b1;
        check("reset_seg", 32'(ifa.seg), 32'h7F);
        check("reset_an_c", 32'(ifc.an), 32'h0);
        step(2);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            en    = vt[i].en;
            value = vt[i].val;
            step(vt[i].n);
            check($sformatf("vec%0d", i),
                  {20'h0, ifa.seg, ifa.an, ifa.frame_done},
                  {20'h0, vt[i].seg, vt[i].an, vt[i].fd});
        end

        // Leading-zero suppression on/off.
        en = 1'b0;
        step(1);
        en    = 1'b1;
        value = 16'h0070;
        step(9);
        check("lz_d1_seg", 32'(ifa.seg), 32'h78);
        step(12);
        check("lz_d3_seg", 32'(ifa.seg), 32'h7F);
        check("lz_d3_an", 32'(ifa.an), 32'h7);
        check("nolz_d3_seg", 32'(ifb.seg), 32'h40);

        // Mid-frame value change held off until the frame boundary.
        en = 1'b0;
        step(1);
        en    = 1'b1;
        value = 16'hAAAA;
        step(9);
        value = 16'h5555;
        step(6);
        check("coh_d2_seg", 32'(ifa.seg), 32'h08);
        step(6);
        check("coh_d3_seg", 32'(ifa.seg), 32'h08);
        step(4);
        check("coh_fd", 32'(ifa.frame_done), 32'h1);
        step(2);
        check("coh_new_seg", 32'(ifa.seg), 32'h12);

        // Enable dropped during digit 2, then restored.
        step(12);
        check("abort_pre_an", 32'(ifa.an), 32'hB);
        en = 1'b0;
        step(1);
        check("abort_dark", {24'h0, ifa.seg, ifa.frame_done}, 32'hFE);
        step(1);
        check("abort_no_fd", 32'(ifa.frame_done), 32'h0);
        en = 1'b1;
        step(3);
        check("restart_an", 32'(ifa.an), 32'hE);

        // Reset mid-DRIVE with enable held high.
        step(13);
        rst   = 1'b1;
        value = 16'h1234;
        step(1);
        check("rst_dark_an", 32'(ifa.an), 32'hF);
        rst = 1'b0;
        step(3);
        check("rst_restart_seg", 32'(ifa.seg), 32'h19);

        // No blank phase, active-high pins.
        en = 1'b0;
        step(1);
        en    = 1'b1;
        value = 16'hF00D;
        step(1);
        for (int d = 0; d < 4; d++) begin
            logic [15:0] v;
            v = 16'hF00D;
            check($sformatf("c_an%0d", d), 32'(ifc.an), 32'(1 << d));
            check($sformatf("c_seg%0d", d), 32'(ifc.seg),
                  32'(dec[4'(v >> (4 * d))]));
            step(4);
        end
        check("c_fd", 32'(ifc.frame_done), 32'h1);

        // Randomized run against the model.
        for (int i = 0; i < 3000; i++) begin
            en  = ($urandom % 64) != 0;
            rst = ($urandom % 500) == 0;
            if (($urandom % 8) == 0)
                value = 16'($urandom) & (16'hFFFF >> (4 * ($urandom % 4)));
            step(1);
        end
        rst = 1'b0;
        step(1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
